// File: rtl/icache_direct_pkg.sv
// Shared types for the direct-mapped instruction cache: address decode,
// frame layout and fill FSM states.
package icache_direct_pkg;

  localparam int SETS  = 16;
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       bytoff;
  } icachef_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    word_t            data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// Handshake: imemload is valid only in a cycle where ihit=1; iload is valid
// only in a cycle where iREN=1 and iwait=0, and iREN/iaddr hold until then.
interface icache_direct_if;
  import icache_direct_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  modport cache (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport dp (
    output imemREN, imemaddr,
    input  ihit, imemload
  );

  modport mem (
    input  iREN, iaddr,
    output iwait, iload
  );

endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-block instruction cache. Hits are served
// combinationally; a miss runs a blocking single-request fill from memory.
module icache_direct
  import icache_direct_pkg::*;
(
  input  logic          CLK,
  input  logic          nRST,
  icache_direct_if.cache cif,
  output icache_state_t state_dbg
);

  icache_frame_t frames [SETS];
  icache_state_t state, next_state;
  word_t         miss_addr;
  icachef_t      req, miss;
  logic          hit, fill, latch_miss;
  logic          unused_bytoff;

  assign req  = icachef_t'(cif.imemaddr);
  assign miss = icachef_t'(miss_addr);
  assign unused_bytoff = ^{req.bytoff, miss.bytoff};

  assign hit = frames[req.idx].valid && (frames[req.idx].tag == req.tag);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
    end else begin
      state <= next_state;
      if (latch_miss) miss_addr <= {cif.imemaddr[31:2], 2'b00};
    end
  end

  // Frames are written only on a completed fill; reset wipes every frame so
  // an aborted fill leaves nothing behind.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) frames[i] <= '0;
    end else if (fill) begin
      frames[miss.idx] <= '{valid: 1'b1, tag: miss.tag, data: cif.iload};
    end
  end

  always_comb begin
    next_state   = state;
    latch_miss   = 1'b0;
    fill         = 1'b0;
    cif.ihit     = 1'b0;
    cif.imemload = '0;
    cif.iREN     = 1'b0;
    cif.iaddr    = '0;
    unique case (state)
      IDLE: begin
        if (cif.imemREN && hit) begin
          cif.ihit     = 1'b1;
          cif.imemload = frames[req.idx].data;
        end else if (cif.imemREN) begin
          latch_miss = 1'b1;
          next_state = FETCH;
        end
      end
      FETCH: begin
        cif.iREN  = 1'b1;
        cif.iaddr = miss_addr;
        if (!cif.iwait) begin
          fill       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct against a set-array reference model.
module tb_icache_direct;
  import icache_direct_pkg::*;

  logic          CLK;
  logic          nRST;
  icache_state_t state_dbg;

  icache_direct_if cif();

  icache_direct dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .cif       (cif.cache),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // reference model: what each set holds, plus the backing memory image
  bit              m_valid [SETS];
  logic [TAG_W-1:0] m_tag  [SETS];
  word_t           m_data  [SETS];
  word_t           mem     [word_t];
  logic [31:0]     exp_q   [$];

  int total_cnt = 0;
  int pass_cnt  = 0;

  function automatic word_t mem_word(input word_t a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < SETS; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_data[i]  = '0;
    end
  endfunction

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // driver: one complete fetch of addr; a miss is served after nwait busy cycles
  task automatic access(input word_t addr, input int nwait, input string nm);
    int    idx;
    word_t al;
    bit    mhit;
    word_t w;
    idx  = int'(addr[IDX_W+1:2]);
    al   = {addr[31:2], 2'b00};
    mhit = m_valid[idx] && (m_tag[idx] == addr[31:IDX_W+2]);
    cif.imemREN  = 1'b1;
    cif.imemaddr = addr;
    cif.iwait    = 1'b1;
    cif.iload    = '0;
    @(negedge CLK);
    total_cnt++;
    if (cif.ihit !== mhit) $display("FAIL %s_hit: got %b want %b addr %h", nm, cif.ihit, mhit, addr);
    else pass_cnt++;
    total_cnt++;
    if (cif.imemload !== (mhit ? m_data[idx] : 32'h0))
      $display("FAIL %s_load: got %h want %h", nm, cif.imemload, mhit ? m_data[idx] : 32'h0);
    else pass_cnt++;
    total_cnt++;
    if (cif.iREN !== 1'b0 || cif.iaddr !== 32'h0)
      $display("FAIL %s_idle_req: got iREN %b iaddr %h want 0 0", nm, cif.iREN, cif.iaddr);
    else pass_cnt++;
    next_cycle();
    if (mhit) return;
    for (int k = 0; k <= nwait; k++) begin
      if (k == nwait) begin
        w         = mem_word(al);
        cif.iwait = 1'b0;
        cif.iload = w;
      end
      @(negedge CLK);
      total_cnt++;
      if (cif.iREN !== 1'b1 || cif.iaddr !== al || cif.ihit !== 1'b0)
        $display("FAIL %s_fetch: got iREN %b iaddr %h ihit %b want 1 %h 0", nm, cif.iREN, cif.iaddr, cif.ihit, al);
      else pass_cnt++;
      next_cycle();
    end
    m_valid[idx] = 1'b1;
    m_tag[idx]   = addr[31:IDX_W+2];
    m_data[idx]  = w;
    exp_q.push_back(w);
    cif.iwait = 1'b1;
    cif.iload = '0;
    @(negedge CLK);
    total_cnt++;
    if (cif.ihit !== 1'b1 || cif.imemload !== exp_q[0])
      $display("FAIL %s_after_fill: got ihit %b load %h want 1 %h", nm, cif.ihit, cif.imemload, exp_q[0]);
    else pass_cnt++;
    void'(exp_q.pop_front());
    next_cycle();
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    cif.imemREN = 1'b1; cif.imemaddr = 32'h40; cif.iwait = 1'b1; cif.iload = '0;
    #2;
    total_cnt++;
    if (cif.ihit !== 1'b0 || cif.iREN !== 1'b0 || cif.iaddr !== 32'h0 || cif.imemload !== 32'h0)
      $display("FAIL reset_outputs: got ihit %b iREN %b iaddr %h load %h want all 0", cif.ihit, cif.iREN, cif.iaddr, cif.imemload);
    else pass_cnt++;
    total_cnt++;
    if (state_dbg !== IDLE) $display("FAIL reset_state: got %0d want IDLE", state_dbg);
    else pass_cnt++;
    repeat (2) next_cycle();
    cif.imemREN = 1'b0;
    nRST = 1'b1;
    model_clear();
    next_cycle();
  endtask

  task automatic test_basic_fill();
    mem[32'h40] = 32'h2108_0004;
    access(32'h40, 0, "basic");
    total_cnt++;
    if (m_data[0] !== 32'h2108_0004) $display("FAIL basic_model: got %h want 21080004", m_data[0]);
    else pass_cnt++;
  endtask

  task automatic test_repeat_hits();
    for (int i = 0; i < 3; i++) begin
      cif.imemREN = 1'b1; cif.imemaddr = 32'h40;
      @(negedge CLK);
      total_cnt++;
      if (cif.ihit !== 1'b1 || cif.imemload !== 32'h2108_0004 || cif.iREN !== 1'b0)
        $display("FAIL repeat_hit%0d: got ihit %b load %h iREN %b want 1 21080004 0", i, cif.ihit, cif.imemload, cif.iREN);
      else pass_cnt++;
      next_cycle();
    end
  endtask

  task automatic test_idle_no_req();
    cif.imemREN = 1'b0; cif.imemaddr = 32'h40;
    repeat (2) begin
      @(negedge CLK);
      total_cnt++;
      if (cif.ihit !== 1'b0 || cif.iREN !== 1'b0 || cif.imemload !== 32'h0)
        $display("FAIL idle_noreq: got ihit %b iREN %b load %h want 0 0 0", cif.ihit, cif.iREN, cif.imemload);
      else pass_cnt++;
      next_cycle();
    end
  endtask

  task automatic test_conflict();
    access(32'h440, 1, "conflict_new");
    total_cnt++;
    if (m_valid[0] && m_tag[0] == 26'h1) $display("FAIL conflict_model: got tag %h want overwritten", m_tag[0]);
    else pass_cnt++;
    access(32'h40, 0, "conflict_old");
  endtask

  task automatic test_wait_states();
    access(32'h100, 5, "wait5");
  endtask

  task automatic test_addr_change();
    word_t w;
    cif.imemREN = 1'b1; cif.imemaddr = 32'h200; cif.iwait = 1'b1;
    @(negedge CLK);
    total_cnt++;
    if (cif.ihit !== 1'b0) $display("FAIL chg_detect: got ihit %b want 0", cif.ihit);
    else pass_cnt++;
    next_cycle();
    cif.imemaddr = 32'h204;
    repeat (2) begin
      @(negedge CLK);
      total_cnt++;
      if (cif.iREN !== 1'b1 || cif.iaddr !== 32'h200)
        $display("FAIL chg_hold: got iREN %b iaddr %h want 1 00000200", cif.iREN, cif.iaddr);
      else pass_cnt++;
      next_cycle();
    end
    w = mem_word(32'h200);
    cif.iwait = 1'b0; cif.iload = w;
    next_cycle();
    m_valid[0] = 1'b1; m_tag[0] = 26'h8; m_data[0] = w;
    cif.iwait = 1'b1; cif.iload = '0;
    access(32'h204, 0, "chg_new");
    access(32'h200, 0, "chg_old");
  endtask

  task automatic test_reset_mid_fetch();
    cif.imemREN = 1'b1; cif.imemaddr = 32'h80; cif.iwait = 1'b1;
    next_cycle();
    @(negedge CLK);
    total_cnt++;
    if (cif.iREN !== 1'b1) $display("FAIL rstmid_pre: got iREN %b want 1", cif.iREN);
    else pass_cnt++;
    #1 nRST = 1'b0;
    #1;
    total_cnt++;
    if (cif.iREN !== 1'b0 || cif.iaddr !== 32'h0 || state_dbg !== IDLE)
      $display("FAIL rstmid_async: got iREN %b iaddr %h state %0d want 0 0 IDLE", cif.iREN, cif.iaddr, state_dbg);
    else pass_cnt++;
    cif.iwait = 1'b0; cif.iload = 32'hdead_beef;
    next_cycle();
    nRST = 1'b1;
    cif.iwait = 1'b1;
    model_clear();
    access(32'h80, 0, "rstmid_prior");
    access(32'h40, 1, "rstmid_old");
  endtask

  task automatic test_random();
    word_t a;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        cif.imemREN = 1'b0; cif.imemaddr = $urandom;
        @(negedge CLK);
        total_cnt++;
        if (cif.ihit !== 1'b0 || cif.iREN !== 1'b0)
          $display("FAIL rand_idle: got ihit %b iREN %b want 0 0", cif.ihit, cif.iREN);
        else pass_cnt++;
        next_cycle();
      end else begin
        a = {$urandom_range(0, 2) * 32'h1000, 26'h0, 6'h0} >> 6;
        a = {18'h0, 2'($urandom_range(0, 2)), 6'h0, 4'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
        access(a, $urandom_range(0, 3), "rand");
      end
    end
  endtask

  initial begin
    nRST = 1'b0;
    cif.imemREN = 1'b0; cif.imemaddr = '0; cif.iwait = 1'b1; cif.iload = '0;
    test_reset();
    test_basic_fill();
    test_repeat_hits();
    test_idle_no_req();
    test_conflict();
    test_wait_states();
    test_addr_change();
    test_reset_mid_fetch();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
